// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multi-cycle multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int LAT_W = 4;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_long(input logic [2:0] code);
        return (code == MULT) || (code == MULTU) || (code == DIV) || (code == DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit with architectural HI/LO: result is computed at the start
// edge and held in temp registers until a fixed-latency counter expires.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        state_dbg
);

    localparam logic [LAT_W-1:0] MULT_CNT = LAT_W'(MULT_LAT - 1);
    localparam logic [LAT_W-1:0] DIV_CNT  = LAT_W'(DIV_LAT - 1);

    state_t           state, state_next;
    logic [LAT_W-1:0] cnt, cnt_next;
    logic             load, done;
    logic             mt_hi, mt_lo;

    logic [31:0] tmp_hi, tmp_lo;
    logic        tmp_wr;

    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    logic [63:0] prod_s, prod_u;
    logic        b_zero;
    logic [31:0] abs_a, abs_b, num, den, quo, rem, quo_s, rem_s;

    // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide goes through magnitudes so 0x80000000 / -1 needs no special case.
    assign b_zero = (B == 32'd0);
    assign abs_a  = A[31] ? -A : A;
    assign abs_b  = B[31] ? -B : B;
    assign num    = (op == DIV) ? abs_a : A;
    assign den    = b_zero ? 32'd1 : ((op == DIV) ? abs_b : B);
    assign quo    = num / den;
    assign rem    = num % den;
    assign quo_s  = (A[31] ^ B[31]) ? -quo : quo;
    assign rem_s  = A[31] ? -rem : rem;

    always_comb begin
        res_hi = tmp_hi;
        res_lo = tmp_lo;
        res_wr = 1'b0;
        case (op)
            MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            DIV: begin
                if (!b_zero) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                    res_wr = 1'b1;
                end
            end
            DIVU: begin
                if (!b_zero) begin
                    res_hi = rem;
                    res_lo = quo;
                    res_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        done       = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_long(op)) begin
                    state_next = RUN;
                    load       = 1'b1;
                    cnt_next   = ((op == MULT) || (op == MULTU)) ? MULT_CNT : DIV_CNT;
                end
                mt_hi = start && (op == MTHI);
                mt_lo = start && (op == MTLO);
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A divide by zero records tmp_wr=0, so completion leaves HI/LO alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmp_hi <= '0;
            tmp_lo <= '0;
            tmp_wr <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            if (load) begin
                tmp_hi <= res_hi;
                tmp_lo <= res_lo;
                tmp_wr <= res_wr;
            end
            if (done && tmp_wr) begin
                HI <= tmp_hi;
                LO <= tmp_lo;
            end
            if (mt_hi) HI <= A;
            if (mt_lo) LO <= A;
        end
    end

    assign busy      = (state == RUN);
    assign stall_req = busy | (start & is_long(op));
    assign state_dbg = state;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of arithmetic vectors plus hand-written
// sequences for move-to, divide by zero, start while busy and mid-op reset.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, stall_req, state_dbg;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] hi_m, lo_m;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the completion edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        check("stall_req_start", {31'd0, stall_req}, 32'd1);
        check("busy_start", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        op    = NONE;
        A     = 32'h0;
        B     = 32'h0;
        for (int i = 0; i < lat; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("stall_run", {31'd0, stall_req}, 32'd1);
            check("state_run", {31'd0, state_dbg}, 32'd1);
            check("hi_hold", HI, hi_m);
            check("lo_hold", LO, lo_m);
            @(negedge clk);
        end
        hi_m = ehi;
        lo_m = elo;
        check("busy_done", {31'd0, busy}, 32'd0);
        check("hi_done", HI, hi_m);
        check("lo_done", LO, lo_m);
    endtask

    // Single-cycle op (move-to or no-op code); called and returns at a negedge.
    task automatic run_short(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = 32'hDEAD_BEEF;
        #1;
        check("stall_short", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        op    = NONE;
        if (o == MTHI) hi_m = a;
        if (o == MTLO) lo_m = a;
        check("busy_short", {31'd0, busy}, 32'd0);
        check("hi_short", HI, hi_m);
        check("lo_short", LO, lo_m);
    endtask

    initial begin
        vecs[0] = '{MULT,  32'hFFFF_FFFD, 32'h0000_0005, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT,  32'h0000_0001, 32'hFFFF_FFFD};
        vecs[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,  32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{DIVU,  32'h0000_0064, 32'h0000_0007, DIV_LAT,  32'h0000_0002, 32'h0000_000E};
        vecs[6] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0010, DIV_LAT,  32'h0000_000F, 32'h0FFF_FFFF};
        vecs[7] = '{MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, MULT_LAT, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[8] = '{MULT,  32'h8000_0000, 32'h8000_0000, MULT_LAT, 32'h4000_0000, 32'h0000_0000};
        vecs[9] = '{MULTU, 32'h8000_0000, 32'h0000_0002, MULT_LAT, 32'h0000_0001, 32'h0000_0000};

        reset = 1'b1;
        start = 1'b0;
        op    = NONE;
        A     = 32'h0;
        B     = 32'h0;
        hi_m  = 32'h0;
        lo_m  = 32'h0;

        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        check("reset_state", {31'd0, state_dbg}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo);
        end

        // No-op and unknown codes leave everything alone.
        run_short(NONE, 32'h1111_1111);
        run_short(3'd7, 32'h2222_2222);

        // Move-to writes, then divides by zero keep HI/LO.
        run_short(MTHI, 32'h0000_1234);
        run_short(MTLO, 32'h0000_5678);
        run_op(DIV,  32'h0000_0064, 32'h0000_0000, DIV_LAT, 32'h0000_1234, 32'h0000_5678);
        run_op(DIVU, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT, 32'h0000_1234, 32'h0000_5678);

        // Start while busy: DIVU and MTHI mid-MULT are ignored.
        start = 1'b1;
        op    = MULT;
        A     = 32'd2;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b1;
        op    = DIVU;
        A     = 32'd9;
        B     = 32'd2;
        check("busy_ign1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        op = MTHI;
        A  = 32'hAAAA_AAAA;
        check("busy_ign2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        op    = NONE;
        for (int i = 2; i < MULT_LAT; i++) begin
            check("busy_ign_run", {31'd0, busy}, 32'd1);
            check("hi_ign_hold", HI, 32'h0000_1234);
            @(negedge clk);
        end
        hi_m = 32'h0;
        lo_m = 32'd6;
        check("busy_ign_done", {31'd0, busy}, 32'd0);
        check("hi_ign", HI, hi_m);
        check("lo_ign", LO, lo_m);
        @(negedge clk);
        check("busy_ign_after", {31'd0, busy}, 32'd0);
        check("lo_ign_after", LO, lo_m);

        // Reset on the third busy cycle of a DIVU discards the result.
        start = 1'b1;
        op    = DIVU;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        op    = NONE;
        @(negedge clk);
        @(negedge clk);
        check("busy_pre_rst", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("busy_rst", {31'd0, busy}, 32'd0);
        check("hi_rst", HI, 32'h0);
        check("lo_rst", LO, 32'h0);
        hi_m = 32'h0;
        lo_m = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DIV_LAT; i++) begin
            @(negedge clk);
            check("busy_post_rst", {31'd0, busy}, 32'd0);
            check("lo_post_rst", LO, 32'h0);
        end
        run_op(MULTU, 32'd4, 32'd4, MULT_LAT, 32'h0, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers. Sits in EX beside the ALU.
- Accepts one operation per start pulse and models a fixed latency per operation class.
- Raises a stall request so the hazard unit freezes the pipeline while the unit is busy.
- Owns architectural HI/LO and services mthi/mtlo writes.

Parameters:
- MULT_LAT, 5, cycles busy is held for mult/multu (1..15)
- DIV_LAT, 10, cycles busy is held for div/divu (1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request, sampled on the rising edge of clk
- op  input  3  operation code (see package)
- A  input  32  rs operand
- B  input  32  rt operand
- busy  output  1  operation in flight
- stall_req  output  1  combinational: busy | (start & op is MULT/MULTU/DIV/DIVU)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- One clock (clk); reset is asynchronous and active-high. While reset is high: busy=0, HI=0, LO=0, counter=0, state=IDLE. Any pending result is discarded, including when reset arrives mid-operation.
- States: IDLE, RUN.
- IDLE, start=1 with MULT/MULTU/DIV/DIVU:
  - Latch the op and compute the 64-bit result into internal temp registers.
  - Load counter with LAT-1.
  - Go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. When counter==0, on that edge: write HI/LO from temp, busy→0, go to IDLE.
- Timing: start sampled at edge k → busy high for exactly LAT cycles (edges k..k+LAT) → HI/LO change at edge k+LAT. Architectural HI/LO never change before completion.
- Back-to-back: start may be asserted in the first cycle after busy falls; that op starts normally.
- start while busy (any op): ignored. The hazard unit guarantees this does not occur; the block must remain robust to it.
- MTHI/MTLO with start=1 in IDLE: HI (resp. LO) ← A at the same edge. No busy; stall_req stays 0. The other register is unchanged.
- op=NONE, or an unknown code, with start=1: no effect.
- Arithmetic rules:
  - MULT: {HI,LO} = signed A × signed B, full 64 bits.
  - MULTU: same, both operands unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder, sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B==0, DIV or DIVU): the op still runs the full DIV_LAT cycles with busy and stall_req asserted. HI and LO are left unchanged at completion.
- stall_req is asserted in the start cycle of a multi-cycle op, so the following instruction is held from that cycle onward.

Decomposition:
- Shared package mdu_pkg:
  - op encodings NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6
  - state encodings IDLE=0, RUN=1
  - constant LAT_W=4 (counter width)
- No sub-module. Arithmetic is behavioural (* and /) computed at the start edge. The counter models the latency only.

Test Plan:
- MULT, A=0xFFFFFFFD (−3), B=5 → busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1 at completion; HI/LO unchanged in earlier cycles.
- MULTU, A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV, A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with B=0 after MTHI A=0x1234 and MTLO A=0x5678 → busy 10 cycles; HI=0x1234, LO=0x5678 afterwards.
- MULT 2×3 started, then start with DIVU 9/2 during busy → DIVU ignored; final HI=0, LO=6; busy falls after 5 cycles.
- DIVU 100/7 started, reset pulsed on the 3rd busy cycle → busy=0, HI=LO=0 immediately. A MULTU 4×4 issued after reset releases completes with LO=16.
